// File: rtl/sg_list_reader_q.sv
// Scatter-gather element reader: assembles 128-bit SG elements from narrow buffer
// words and holds them in a show-ahead prefetch queue with slot reservation.
module sg_list_reader_q #(
    parameter int unsigned C_DATA_WIDTH = 64,
    parameter int unsigned C_DEPTH      = 4,
    parameter int unsigned C_SKIP_ZERO  = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [C_DATA_WIDTH-1:0]   BUF_DATA,
    input  logic                      BUF_DATA_EMPTY,
    output logic                      BUF_DATA_REN,
    input  logic                      FLUSH,
    output logic                      VALID,
    output logic                      EMPTY,
    input  logic                      REN,
    output logic [63:0]               ADDR,
    output logic [31:0]               LEN,
    output logic [$clog2(C_DEPTH):0]  COUNT
);

    localparam int unsigned BEATS  = 128 / C_DATA_WIDTH;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PTR_W  = $clog2(C_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    logic [BEAT_W-1:0]             iss_beat_q, iss_beat_d;
    logic [BEAT_W-1:0]             rx_beat_q, rx_beat_d;
    logic                          inflight_q, inflight_d;
    logic [127:0]                  asm_q, asm_d;
    logic [CNT_W-1:0]              resv_q, resv_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
    logic [C_DEPTH-1:0][63:0]      addr_mem_q, addr_mem_d;
    logic [C_DEPTH-1:0][31:0]      len_mem_q, len_mem_d;

    logic         buf_ren;
    logic         rd_acc;
    logic         rd_first;
    logic         complete;
    logic         skip;
    logic         push;
    logic         pop;
    logic [7:0]   beat_lsb;
    logic [127:0] elem;
    logic         unused_rsvd;

    // Datapath, reservation accounting and queue next-state
    always_comb begin
        buf_ren     = !RST && !FLUSH && ((iss_beat_q != '0) || (resv_q < CNT_W'(C_DEPTH)));
        rd_acc      = buf_ren && !BUF_DATA_EMPTY;
        rd_first    = rd_acc && (iss_beat_q == '0);

        beat_lsb    = 8'(32'(rx_beat_q) * C_DATA_WIDTH);
        elem        = asm_q;
        elem[beat_lsb +: C_DATA_WIDTH] = BUF_DATA;
        unused_rsvd = ^elem[127:96];

        // Data returning in a flush cycle is dropped
        complete    = inflight_q && !FLUSH && (rx_beat_q == BEAT_W'(BEATS - 1));
        skip        = complete && (C_SKIP_ZERO != 0) && (elem[95:64] == 32'd0);
        push        = complete && !skip;
        pop         = REN && (count_q != '0) && !FLUSH;

        iss_beat_d  = iss_beat_q;
        rx_beat_d   = rx_beat_q;
        inflight_d  = rd_acc;
        asm_d       = asm_q;
        resv_d      = resv_q + CNT_W'(rd_first) - CNT_W'(pop) - CNT_W'(skip);
        count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        addr_mem_d  = addr_mem_q;
        len_mem_d   = len_mem_q;

        if (rd_acc) begin
            iss_beat_d = (iss_beat_q == BEAT_W'(BEATS - 1)) ? '0 : iss_beat_q + BEAT_W'(1);
        end
        if (inflight_q) begin
            rx_beat_d = (rx_beat_q == BEAT_W'(BEATS - 1)) ? '0 : rx_beat_q + BEAT_W'(1);
            asm_d     = elem;
        end
        if (push) begin
            addr_mem_d[wr_ptr_q] = elem[63:0];
            len_mem_d[wr_ptr_q]  = elem[95:64];
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (FLUSH) begin
            iss_beat_d = '0;
            rx_beat_d  = '0;
            inflight_d = 1'b0;
            resv_d     = '0;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            iss_beat_q <= '0;
            rx_beat_q  <= '0;
            inflight_q <= 1'b0;
            asm_q      <= '0;
            resv_q     <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            addr_mem_q <= '0;
            len_mem_q  <= '0;
        end else begin
            iss_beat_q <= iss_beat_d;
            rx_beat_q  <= rx_beat_d;
            inflight_q <= inflight_d;
            asm_q      <= asm_d;
            resv_q     <= resv_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            addr_mem_q <= addr_mem_d;
            len_mem_q  <= len_mem_d;
        end
    end

    // Show-ahead head; EMPTY tracks the buffer flag combinationally
    always_comb begin
        BUF_DATA_REN = buf_ren;
        VALID        = (count_q != '0);
        COUNT        = count_q;
        ADDR         = addr_mem_q[rd_ptr_q];
        LEN          = len_mem_q[rd_ptr_q];
        EMPTY        = BUF_DATA_EMPTY && (iss_beat_q == '0) && !inflight_q && (count_q == '0);
    end

endmodule
